// File: rtl/pcpi_initiator.sv
// pcpi_initiator: issues one PCPI command at a time and returns result or timeout error.
// Define PCPI_LAT_CNT_EN to add the rsp_cycles latency counter output.
module pcpi_initiator #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_insn,
  input  logic [31:0] cmd_rs1,
  input  logic [31:0] cmd_rs2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_wr,
  output logic        rsp_err,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready
`ifdef PCPI_LAT_CNT_EN
  ,
  output logic [CNT_W-1:0] rsp_cycles
`endif
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tmo;
  logic          w_accept;
  logic          w_hit;
  logic          w_tmo_end;

  if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
    $error("pcpi_initiator: TIMEOUT must be >= 2 and CNT_W >= 1");
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    pcpi_valid = 1'b0;
    rsp_valid  = 1'b0;
    w_accept   = 1'b0;
    w_hit      = 1'b0;
    w_tmo_end  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        pcpi_valid = 1'b1;
        if (pcpi_ready) begin
          w_hit  = 1'b1;
          w_next = S_RESP;
        end else if (!pcpi_wait &&
                     r_tmo == TW'(TIMEOUT - 1)) begin
          w_tmo_end = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // a responder still holding ready must not see the next command
        if (!pcpi_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      pcpi_insn <= '0;
      pcpi_rs1  <= '0;
      pcpi_rs2  <= '0;
      rsp_data  <= '0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        pcpi_insn <= cmd_insn;
        pcpi_rs1  <= cmd_rs1;
        pcpi_rs2  <= cmd_rs2;
        r_tmo     <= '0;
      end else if (r_state == S_ISSUE) begin
        if (pcpi_wait) r_tmo <= '0;
        else           r_tmo <= r_tmo + TW'(1);
      end
      if (w_hit) begin
        rsp_data <= pcpi_wr ? pcpi_rd : 32'h0;
        rsp_wr   <= pcpi_wr;
        rsp_err  <= 1'b0;
      end else if (w_tmo_end) begin
        rsp_data <= 32'h0;
        rsp_wr   <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end
  end

`ifdef PCPI_LAT_CNT_EN
  logic [CNT_W-1:0] r_lat;
  logic [CNT_W-1:0] w_lat_inc;

  assign w_lat_inc = (&r_lat) ? r_lat : r_lat + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lat      <= '0;
      rsp_cycles <= '0;
    end else begin
      if (w_accept)        r_lat <= '0;
      else if (pcpi_valid) r_lat <= w_lat_inc;
      if (w_hit || w_tmo_end) rsp_cycles <= w_lat_inc;
    end
  end
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// Scoreboard bench for pcpi_initiator with a scripted PCPI responder.
// Works with or without PCPI_LAT_CNT_EN.
module tb_pcpi_initiator;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_insn = '0;
  logic [31:0] cmd_rs1 = '0;
  logic [31:0] cmd_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic        rsp_err;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic        pcpi_wait = 1'b0;
  logic        pcpi_ready = 1'b0;
`ifdef PCPI_LAT_CNT_EN
  logic [CNT_W-1:0] rsp_cycles;
`endif

  pcpi_initiator #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_insn  (cmd_insn),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_wr    (rsp_wr),
    .rsp_err   (rsp_err),
    .pcpi_valid(pcpi_valid),
    .pcpi_insn (pcpi_insn),
    .pcpi_rs1  (pcpi_rs1),
    .pcpi_rs2  (pcpi_rs2),
    .pcpi_wr   (pcpi_wr),
    .pcpi_rd   (pcpi_rd),
    .pcpi_wait (pcpi_wait),
    .pcpi_ready(pcpi_ready)
`ifdef PCPI_LAT_CNT_EN
    ,
    .rsp_cycles(rsp_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_n;
    int          idle_n;
    int          hold;
    bit          silent;
    bit          wr;
    logic [31:0] rd;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } rcfg_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    bit          wr;
    bit          err;
    int          lat;
  } exp_t;

  rcfg_t rq[$];
  exp_t  exq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t_pv   = 0;
  int t_rv   = 0;
  int n_rsp  = 0;
  bit prev_pv = 1'b0;
  bit prev_rv = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // monitor: latency tracking and scoreboard pops
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (resetn) begin
      if (pcpi_valid && !prev_pv) t_pv = cyc;
      if (rsp_valid && !prev_rv) begin
        t_rv = cyc;
        n_rsp++;
      end
      if (pcpi_ready)
        chk("cmd_ready_while_pcpi_ready",
            {31'b0, cmd_ready}, 32'h0);
      if (rsp_valid && rsp_ready) begin
        if (exq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data %h err %b required none",
                   rsp_data, rsp_err);
        end else begin
          e = exq.pop_front();
          chk($sformatf("rsp_data#%0d", e.id), rsp_data, e.data);
          chk($sformatf("rsp_wr#%0d", e.id), {31'b0, rsp_wr},
              {31'b0, e.wr});
          chk($sformatf("rsp_err#%0d", e.id), {31'b0, rsp_err},
              {31'b0, e.err});
          chk($sformatf("latency#%0d", e.id), t_rv - t_pv, e.lat);
`ifdef PCPI_LAT_CNT_EN
          chk($sformatf("rsp_cycles#%0d", e.id),
              {{(32-CNT_W){1'b0}}, rsp_cycles}, e.lat);
`endif
        end
      end
    end
    prev_pv = pcpi_valid;
    prev_rv = rsp_valid;
  end

  // scripted responder: wait_n wait cycles, idle_n idle cycles, then ready
  initial begin
    rcfg_t c;
    int ph = 0;
    int wc = 0;
    int ic = 0;
    int hc = 0;
    c = '{0, 0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    forever begin
      @(posedge clk);
      #1;
      if (ph == 3) begin
        hc--;
        if (hc == 0) begin
          pcpi_ready = 1'b0;
          pcpi_wr    = 1'b0;
          pcpi_rd    = '0;
          ph         = 0;
        end
      end else if (ph == 4) begin
        if (!pcpi_valid) ph = 0;
      end
      if (ph == 0 && pcpi_valid && rq.size() > 0) begin
        c = rq.pop_front();
        chk("pcpi_insn", pcpi_insn, c.insn);
        chk("pcpi_rs1", pcpi_rs1, c.rs1);
        chk("pcpi_rs2", pcpi_rs2, c.rs2);
        wc = c.wait_n;
        ic = c.idle_n;
        ph = 1;
      end
      if (ph == 1) begin
        if (wc > 0) begin
          pcpi_wait = 1'b1;
          wc--;
        end else begin
          pcpi_wait = 1'b0;
          ph = 2;
        end
      end
      if (ph == 2) begin
        if (ic > 0) ic--;
        else if (c.silent) ph = 4;
        else begin
          pcpi_ready = 1'b1;
          pcpi_wr    = c.wr;
          pcpi_rd    = c.rd;
          hc         = c.hold;
          ph         = 3;
        end
      end
    end
  end

  task automatic issue(input int id,
                       input logic [31:0] insn, rs1, rs2,
                       input int wn, inn, hold,
                       input bit silent, wr,
                       input logic [31:0] rd,
                       input bit expect_rsp,
                       input logic [31:0] e_data,
                       input bit e_wr, e_err,
                       input int e_lat);
    int n;
    rq.push_back('{wn, inn, hold, silent, wr, rd, insn, rs1, rs2});
    if (expect_rsp)
      exq.push_back('{id, e_data, e_wr, e_err, e_lat});
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_insn  = insn;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) bound_fail($sformatf("cmd_accept#%0d", id));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exq.size() != 0 || !cmd_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) bound_fail(name);
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    chk("reset_pcpi_valid", {31'b0, pcpi_valid}, 32'h0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("reset_pcpi_insn", pcpi_insn, 32'h0);
`ifdef PCPI_LAT_CNT_EN
    chk("reset_rsp_cycles", {{(32-CNT_W){1'b0}}, rsp_cycles}, 32'h0);
`endif
    resetn = 1'b1;

    issue(1, 32'h00B5050B, 32'h3F800000, 32'h40000000,
          8, 0, 1, 1'b0, 1'b1, 32'h40400000,
          1'b1, 32'h40400000, 1'b1, 1'b0, 9);
    issue(2, 32'h0000000B, 32'h1, 32'h2,
          0, 0, 1, 1'b1, 1'b0, 32'h0,
          1'b1, 32'h0, 1'b0, 1'b1, 16);
    issue(3, 32'h0200000B, 32'hA5A5A5A5, 32'h5A5A5A5A,
          100, 0, 1, 1'b0, 1'b1, 32'h12345678,
          1'b1, 32'h12345678, 1'b1, 1'b0, 101);
    issue(4, 32'h0400000B, 32'h3, 32'h4,
          0, 0, 1, 1'b0, 1'b0, 32'hDEADBEEF,
          1'b1, 32'h0, 1'b0, 1'b0, 1);
    issue(5, 32'h0600000B, 32'h5, 32'h6,
          0, 15, 1, 1'b0, 1'b1, 32'hCAFEF00D,
          1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 16);
    issue(6, 32'h0800000B, 32'h7, 32'h8,
          0, 14, 1, 1'b0, 1'b1, 32'h00000001,
          1'b1, 32'h00000001, 1'b1, 1'b0, 15);
    issue(7, 32'h0A00000B, 32'h9, 32'hA,
          3, 0, 1, 1'b1, 1'b0, 32'h0,
          1'b1, 32'h0, 1'b0, 1'b1, 19);
    issue(8, 32'h0C00000B, 32'hB, 32'hC,
          0, 0, 2, 1'b0, 1'b1, 32'h11111111,
          1'b1, 32'h11111111, 1'b1, 1'b0, 1);
    issue(9, 32'h0E00000B, 32'hD, 32'hE,
          2, 0, 1, 1'b0, 1'b1, 32'h22222222,
          1'b1, 32'h22222222, 1'b1, 1'b0, 3);
    issue(10, 32'h1000000B, 32'hF, 32'h10,
          0, 0, 4, 1'b0, 1'b1, 32'h33333333,
          1'b1, 32'h33333333, 1'b1, 1'b0, 1);
    issue(11, 32'h1200000B, 32'h11, 32'h12,
          1, 0, 1, 1'b0, 1'b1, 32'h44444444,
          1'b1, 32'h44444444, 1'b1, 1'b0, 2);
    wait_idle("idle_before_stall");

    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    issue(12, 32'h1400000B, 32'h13, 32'h14,
          0, 0, 1, 1'b0, 1'b1, 32'h55555555,
          1'b1, 32'h55555555, 1'b1, 1'b0, 1);
    n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) bound_fail("stall_rsp_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      chk("stall_rsp_data", rsp_data, 32'h55555555);
      chk("stall_rsp_wr", {31'b0, rsp_wr}, 32'h1);
      chk("stall_cmd_ready", {31'b0, cmd_ready}, 32'h0);
      chk("stall_pcpi_valid", {31'b0, pcpi_valid}, 32'h0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_idle("idle_before_reset");

    seen = n_rsp;
    issue(13, 32'h1600000B, 32'h15, 32'h16,
          0, 0, 1, 1'b1, 1'b0, 32'h0,
          1'b0, 32'h0, 1'b0, 1'b0, 0);
    repeat (2) @(negedge clk);
    chk("pre_reset_pcpi_valid", {31'b0, pcpi_valid}, 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_pcpi_valid", {31'b0, pcpi_valid}, 32'h0);
    chk("mid_reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("mid_reset_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    chk("dropped_cmd_no_rsp", n_rsp, seen);
    chk("after_reset_pcpi_valid", {31'b0, pcpi_valid}, 32'h0);

    wait_idle("final_drain");
    chk("scoreboard_empty", exq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
